recursion_scheduler: RTL

RECURSION_SCHEDULER -- requirements
Module: recursion_scheduler

---
 rtl/recursion_pkg.sv | 23 ++
 rtl/recursion_watchdog.sv | 31 +++
 rtl/recursion_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/recursion_pkg.sv
// Shared types and widths for the forward/backward recursion sweep; also imported
// by the alpha/beta matrix storage and the soft forward/backward units.
package recursion_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_FINISH,
    S_ERR
  } sched_state_e;

  localparam int DEF_STEPS   = 10;
  localparam int DEF_TIMEOUT = 64;
  localparam int TW_DEF      = $clog2(DEF_STEPS + 1);

  // Width of the per-step WAIT counter; it must be able to hold the value TIMEOUT.
  function automatic int to_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/recursion_watchdog.sv
// Per-step WAIT timer: counts while run is high, clears otherwise, and flags the
// cycle in which the count would reach TIMEOUT.
module recursion_watchdog
  import recursion_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int TO_W = to_w(TIMEOUT);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt != TO_W'(TIMEOUT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // High in the TIMEOUT-th WAIT cycle, so the FSM sees exactly TIMEOUT WAIT cycles.
  assign expired = run && (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/recursion_scheduler.sv
// Sequencer for the forward/backward recursion: issues step t to both units,
// joins their completion pulses, commits alpha[t]/beta[n-t] and loops to n-1.
module recursion_scheduler
  import recursion_pkg::*;
#(
  parameter int  N       = 16,
  parameter int  n       = DEF_STEPS,
  parameter int  TIMEOUT = DEF_TIMEOUT,
  localparam int TW      = $clog2(n + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          fwd_calc,
  output logic [TW-1:0] fwd_t,
  input  logic          fwd_done,
  output logic          bwd_calc,
  output logic [TW-1:0] bwd_t,
  input  logic          bwd_done,
  output logic          alpha_we,
  output logic [TW-1:0] alpha_idx,
  output logic          beta_we,
  output logic [TW-1:0] beta_idx,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [TW-1:0] T_LAST  = TW'(n - 1);
  localparam logic [TW-1:0] N_STEPS = TW'(n);

  if (N < 1 || n < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("recursion_scheduler: N, n and TIMEOUT must all be positive");
  end

  sched_state_e  state, state_nxt;
  logic [TW-1:0] t, t_nxt;
  logic          fdone, bdone, fdone_nxt, bdone_nxt;
  logic          both_done, expired;

  recursion_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == S_WAIT),
    .expired (expired)
  );

  // A pulse in the current cycle joins with a flag captured earlier.
  assign both_done = (fdone | fwd_done) & (bdone | bwd_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      t     <= '0;
      fdone <= 1'b0;
      bdone <= 1'b0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      fdone <= fdone_nxt;
      bdone <= bdone_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    fdone_nxt = fdone;
    bdone_nxt = bdone;
    if (abort) begin
      state_nxt = S_IDLE;
      t_nxt     = '0;
      fdone_nxt = 1'b0;
      bdone_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_nxt = S_ISSUE;
            t_nxt     = '0;
            fdone_nxt = 1'b0;
            bdone_nxt = 1'b0;
          end
        end
        S_ISSUE: begin
          state_nxt = S_WAIT;
          fdone_nxt = 1'b0;
          bdone_nxt = 1'b0;
        end
        S_WAIT: begin
          fdone_nxt = fdone | fwd_done;
          bdone_nxt = bdone | bwd_done;
          if (both_done) begin
            state_nxt = S_COMMIT;
          end else if (expired) begin
            state_nxt = S_ERR;
          end
        end
        S_COMMIT: begin
          fdone_nxt = 1'b0;
          bdone_nxt = 1'b0;
          if (t == T_LAST) begin
            state_nxt = S_FINISH;
          end else begin
            t_nxt     = t + 1'b1;
            state_nxt = S_ISSUE;
          end
        end
        S_FINISH: begin
          state_nxt = S_IDLE;
          t_nxt     = '0;
        end
        default: begin
          state_nxt = S_IDLE;
          t_nxt     = '0;
        end
      endcase
    end
  end

  // Indices are driven only alongside their strobes so idle and reset read as all-zero.
  always_comb begin
    fwd_calc  = 1'b0;
    fwd_t     = '0;
    bwd_calc  = 1'b0;
    bwd_t     = '0;
    alpha_we  = 1'b0;
    alpha_idx = '0;
    beta_we   = 1'b0;
    beta_idx  = '0;
    busy      = (state != S_IDLE) && (state != S_ERR);
    done      = (state == S_FINISH);
    error     = (state == S_ERR);
    if (state == S_ISSUE) begin
      fwd_calc = 1'b1;
      fwd_t    = t;
      bwd_calc = 1'b1;
      bwd_t    = N_STEPS - t;
    end
    if (state == S_COMMIT) begin
      alpha_we  = 1'b1;
      alpha_idx = t;
      beta_we   = 1'b1;
      beta_idx  = N_STEPS - t;
    end
  end

endmodule
